// File: rtl/mdu_seq_ctrl_if.sv
// mdu_seq_ctrl_if: request/response bundle between the execute stage and the
// iterative multiply/divide sequencer. The master side issues requests, the
// slave side (the sequencer) returns busy/done/result.
interface mdu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: sequencer for the multi-cycle RISC-V M-extension unit.
// Runs a shift-add multiplier or restoring divider over DATA_WIDTH cycles on
// operand magnitudes, then applies sign correction and the RISC-V special
// cases (divide by zero, signed overflow).
// Optional feature: define MDU_FAST_PATH_EN to resolve divide-by-zero, signed
// overflow and zero-operand multiplies in one cycle without asserting busy.
module mdu_seq_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    mdu_seq_ctrl_if.slave     bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    // Divide family (ops 4..7) with a zero divisor.
    function automatic logic div_zero(input logic [2:0] op, input logic [W-1:0] b);
        return op[2] && (b == '0);
    endfunction

    // Signed DIV/REM of the most negative value by -1.
    function automatic logic sgn_ovf(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        return ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    endfunction

    // Architectural result of a special case; op[1] separates REM from DIV.
    function automatic logic [W-1:0] special_value(input logic [2:0] op,
                                                   input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic [W-1:0] v;
        v = '0;
        if (div_zero(op, b))
            v = op[1] ? a : '1;
        else if (sgn_ovf(op, a, b))
            v = op[1] ? '0 : MIN_NEG;
        return v;
    endfunction

`ifdef MDU_FAST_PATH_EN
    // Requests whose answer is known without iterating.
    function automatic logic special_hit(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        return div_zero(op, b) || sgn_ovf(op, a, b) ||
               (!op[2] && ((a == '0) || (b == '0)));
    endfunction
`endif

    logic [2:0]       state_q,   state_d;
    logic [2:0]       op_q,      op_d;
    logic [W-1:0]     rs1_q,     rs1_d;
    logic [W-1:0]     rs2_q,     rs2_d;
    logic [W-1:0]     addend_q,  addend_d;
    logic [W-1:0]     shreg_q,   shreg_d;
    logic [2*W-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             neg_res_q, neg_res_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [W-1:0]     result_q,  result_d;

    logic             sign_a, sign_b;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next;
    logic [W:0]       rem_sh, div_diff;
    logic [2*W-1:0]   div_next;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix, rem_fix, fix_result;

    // Datapath: operand conditioning, one iteration step and final correction.
    always_comb begin
        sign_a = rs1_q[W-1] && ((op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                                (op_q == OP_DIV)  || (op_q == OP_REM));
        sign_b = rs2_q[W-1] && ((op_q == OP_MULH) || (op_q == OP_DIV) ||
                                (op_q == OP_REM));
        mag_a  = sign_a ? -rs1_q : rs1_q;
        mag_b  = sign_b ? -rs2_q : rs2_q;

        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (shreg_q[0] ? addend_q : '0)};
        mul_next = {mul_sum, acc_q[W-1:1]};

        rem_sh   = {acc_q[2*W-1:W], shreg_q[W-1]};
        div_diff = rem_sh - {1'b0, addend_q};
        if (!div_diff[W])
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        else
            div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_res_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        if (op_q[2]) begin
            if (div_zero(op_q, rs2_q) || sgn_ovf(op_q, rs1_q, rs2_q))
                fix_result = special_value(op_q, rs1_q, rs2_q);
            else
                fix_result = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_result = (op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    // Control FSM and next-state values for every register.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        addend_d  = addend_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    op_d  = bus.op_i;
                    rs1_d = bus.rs1_i;
                    rs2_d = bus.rs2_i;
`ifdef MDU_FAST_PATH_EN
                    if (special_hit(bus.op_i, bus.rs1_i, bus.rs2_i)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = special_value(bus.op_i, bus.rs1_i, bus.rs2_i);
                    end else begin
                        state_d = S_PREP;
                    end
`else
                    state_d = S_PREP;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                addend_d  = op_q[2] ? mag_b : mag_a;
                shreg_d   = op_q[2] ? mag_a : mag_b;
                neg_res_d = (op_q == OP_REM) ? sign_a : (sign_a ^ sign_b);
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = S_CALC;
            end
            S_CALC: begin
                if (op_q[2]) begin
                    acc_d   = div_next;
                    shreg_d = {shreg_q[W-2:0], 1'b0};
                end else begin
                    acc_d   = mul_next;
                    shreg_d = {1'b0, shreg_q[W-1:1]};
                end
                if (cnt_q == CNT_W'(W - 1))
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                result_d = fix_result;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            addend_q  <= '0;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            addend_q  <= addend_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: directed self-checking bench for mdu_seq_ctrl.
// Expected special-case latency follows MDU_FAST_PATH_EN.
module tb_mdu_seq_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   cyc;
    int   done_seen;

`ifdef MDU_FAST_PATH_EN
    localparam int   SP_LAT  = 1;
    localparam logic SP_BUSY = 1'b0;
`else
    localparam int   SP_LAT  = 35;
    localparam logic SP_BUSY = 1'b1;
`endif

    mdu_seq_ctrl_if #(.DATA_WIDTH(32)) bus ();

    mdu_seq_ctrl #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one sampling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Cycles counted from the request edge; bounded so a stuck DUT cannot hang.
    task automatic waitDone(input int start_cyc, output int cycles);
        cycles = start_cyc;
        while (!bus.done_o && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input logic exp_busy);
        int c;
        applyStimulus(op, a, b);
        checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'(exp_busy));
        waitDone(1, c);
        checkOutput({tag, "_lat"}, 32'(c), 32'(lat));
        checkOutput({tag, "_res"}, bus.result_o, exp);
        checkOutput({tag, "_busy_done"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.op_i     = 3'd0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_busy",   32'(bus.busy_o), 32'd0);
        checkOutput("reset_done",   32'(bus.done_o), 32'd0);
        checkOutput("reset_result", bus.result_o,    32'd0);

        runOp("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35, 1'b1);
        tick();
        runOp("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35, 1'b1);
        tick();
        runOp("div_7_m2",   3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 1'b1);
        tick();
        runOp("rem_7_m2",   3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         35, 1'b1);
        tick();
        runOp("mulhsu_ff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b1);
        tick();
        runOp("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b1);
        tick();
        runOp("mul_ff",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         35, 1'b1);
        tick();
        runOp("mulh_m2_3",  3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 35, 1'b1);
        tick();

        runOp("divu_by0",   3'd5, 32'd77,        32'd0,         32'hFFFF_FFFF, SP_LAT, SP_BUSY);
        tick();
        runOp("remu_by0",   3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, SP_LAT, SP_BUSY);
        tick();
        runOp("rem_m5_by0", 3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SP_LAT, SP_BUSY);
        tick();
        runOp("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT, SP_BUSY);
        tick();
        runOp("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SP_LAT, SP_BUSY);
        tick();
        runOp("mul_zero",   3'd0, 32'd0,         32'd1234,      32'd0,         SP_LAT, SP_BUSY);
        tick();

        // Back-to-back: second request issued in the DONE cycle of the first.
        runOp("b2b_mul",    3'd0, 32'd3,         32'd5,         32'd15,        35, 1'b1);
        runOp("b2b_divu",   3'd5, 32'd100,       32'd7,         32'd14,        35, 1'b1);

        // Flush at counter 10: no done, result held.
        applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 11; i++) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("flush_busy",   32'(bus.busy_o), 32'd0);
        checkOutput("flush_done",   32'(bus.done_o), 32'd0);
        checkOutput("flush_result", bus.result_o,    32'd14);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) done_seen++;
            tick();
        end
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);
        checkOutput("flush_hold",    bus.result_o,   32'd14);

        // Flush and start together: request dropped.
        bus.flush_i = 1'b1;
        applyStimulus(3'd0, 32'd6, 32'd7);
        bus.flush_i = 1'b0;
        checkOutput("flush_start_busy", 32'(bus.busy_o), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) done_seen++;
            tick();
        end
        checkOutput("flush_start_no_done", 32'(done_seen), 32'd0);

        // Reset at counter 20 clears all outputs.
        applyStimulus(3'd0, 32'd6, 32'd7);
        for (int i = 0; i < 21; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_busy",   32'(bus.busy_o), 32'd0);
        checkOutput("rst_mid_done",   32'(bus.done_o), 32'd0);
        checkOutput("rst_mid_result", bus.result_o,    32'd0);
        tick();

        // Start pulsed during CALC is ignored.
        applyStimulus(3'd5, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(3'd0, 32'd6, 32'd7);
        waitDone(6, cyc);
        checkOutput("ign_start_lat", 32'(cyc),     32'd35);
        checkOutput("ign_start_res", bus.result_o, 32'd14);
        tick();
        checkOutput("ign_start_idle", 32'(bus.busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
